// File: rtl/reorder_buffer_pkg.sv
// rtl/reorder_buffer_pkg.sv - shared reorder buffer sizes, types, reset values and entry-type encodings
package reorder_buffer_pkg;

    localparam int ROB_SIZE = 16;

    typedef logic [4:0]  rob_id_type;
    typedef logic [3:0]  rob_idx_type;
    typedef logic [4:0]  reg_type;
    typedef logic [31:0] data_type;
    typedef logic [31:0] addr_type;

    localparam rob_id_type ROB_ID_RESET = 5'd0;
    localparam reg_type    REG_RESET    = 5'd0;
    localparam data_type   DATA_RESET   = 32'd0;
    localparam addr_type   ADDR_RESET   = 32'd0;

    typedef enum logic [1:0] {
        ROB_TYPE_ALU    = 2'd0,
        ROB_TYPE_STORE  = 2'd1,
        ROB_TYPE_BRANCH = 2'd2
    } rob_type_e;

    // Ids 1..16 name entries; 0 and 17..31 name nothing.
    function automatic logic id_is_entry(input rob_id_type id);
        return (id != ROB_ID_RESET) && (id <= rob_id_type'(ROB_SIZE));
    endfunction

    function automatic rob_idx_type id_to_idx(input rob_id_type id);
        return id[3:0] - 4'd1;
    endfunction

    function automatic rob_id_type idx_to_id(input rob_idx_type idx);
        return {1'b0, idx} + 5'd1;
    endfunction

endpackage

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - 16-entry in-order-commit reorder buffer with CDB capture, operand bypass and branch rollback
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic       clk_in,               // system clock
    input  logic       rst_in,               // asynchronous active-low reset
    input  logic       rdy_in,               // global ready, low freezes state
    input  logic       alloc_valid_in,       // dispatch request
    input  reg_type    alloc_rd_in,          // destination register, 0 = none
    input  logic [1:0] alloc_type_in,        // 0 alu/load, 1 store, 2 branch
    input  addr_type   alloc_pc_in,          // instruction pc
    input  logic       alloc_pred_taken_in,  // predicted branch direction
    output rob_id_type alloc_id_out,         // id granted to current request
    output logic       full_out,             // all 16 entries occupied
    input  rob_id_type q1_id_in,             // operand 1 producer id
    input  rob_id_type q2_id_in,             // operand 2 producer id
    output logic       q1_ready_out,
    output logic       q2_ready_out,
    output data_type   q1_value_out,
    output data_type   q2_value_out,
    input  logic       result_valid_in,      // cdb broadcast
    input  rob_id_type result_id_in,
    input  data_type   result_value_in,
    input  logic       result_taken_in,
    input  addr_type   result_target_in,
    output logic       commit_flag_out,      // one pulse per retired entry
    output reg_type    rd_to_reg_out,
    output data_type   V_to_reg_out,
    output rob_id_type Q_to_reg_out,
    output logic       store_commit_out,
    output logic       rollback_flag_out,
    output addr_type   rollback_pc_out
);

    logic        valid_q  [ROB_SIZE];
    logic        ready_q  [ROB_SIZE];
    rob_type_e   type_q   [ROB_SIZE];
    reg_type     rd_q     [ROB_SIZE];
    data_type    value_q  [ROB_SIZE];
    addr_type    pc_q     [ROB_SIZE];
    logic        pred_q   [ROB_SIZE];
    logic        taken_q  [ROB_SIZE];
    addr_type    target_q [ROB_SIZE];

    rob_idx_type head_q;
    rob_idx_type tail_q;
    logic [4:0]  count_q;

    logic        do_alloc;
    logic        do_commit;
    logic        mispredict;
    logic        result_hit;
    rob_idx_type result_idx;
    rob_idx_type q1_idx;
    rob_idx_type q2_idx;

    assign full_out     = (count_q == 5'd16);
    assign alloc_id_out = idx_to_id(tail_q);

    assign do_alloc   = alloc_valid_in && !full_out && rdy_in;
    assign do_commit  = rdy_in && (count_q != 5'd0) && valid_q[head_q] && ready_q[head_q];
    assign mispredict = do_commit && (type_q[head_q] == ROB_TYPE_BRANCH)
                        && (taken_q[head_q] != pred_q[head_q]);

    assign result_idx = id_to_idx(result_id_in);
    assign result_hit = result_valid_in && id_is_entry(result_id_in);
    assign q1_idx     = id_to_idx(q1_id_in);
    assign q2_idx     = id_to_idx(q2_id_in);

    // Stored result wins; otherwise a same-cycle CDB broadcast is forwarded.
    always_comb begin
        q1_ready_out = 1'b0;
        q1_value_out = DATA_RESET;
        if (id_is_entry(q1_id_in)) begin
            if (ready_q[q1_idx]) begin
                q1_ready_out = 1'b1;
                q1_value_out = value_q[q1_idx];
            end else if (result_valid_in && (result_id_in == q1_id_in)) begin
                q1_ready_out = 1'b1;
                q1_value_out = result_value_in;
            end
        end
    end

    always_comb begin
        q2_ready_out = 1'b0;
        q2_value_out = DATA_RESET;
        if (id_is_entry(q2_id_in)) begin
            if (ready_q[q2_idx]) begin
                q2_ready_out = 1'b1;
                q2_value_out = value_q[q2_idx];
            end else if (result_valid_in && (result_id_in == q2_id_in)) begin
                q2_ready_out = 1'b1;
                q2_value_out = result_value_in;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head_q            <= '0;
            tail_q            <= '0;
            count_q           <= '0;
            commit_flag_out   <= 1'b0;
            rd_to_reg_out     <= REG_RESET;
            V_to_reg_out      <= DATA_RESET;
            Q_to_reg_out      <= ROB_ID_RESET;
            store_commit_out  <= 1'b0;
            rollback_flag_out <= 1'b0;
            rollback_pc_out   <= ADDR_RESET;
            for (int i = 0; i < ROB_SIZE; i++) begin
                valid_q[i]  <= 1'b0;
                ready_q[i]  <= 1'b0;
                type_q[i]   <= ROB_TYPE_ALU;
                rd_q[i]     <= REG_RESET;
                value_q[i]  <= DATA_RESET;
                pc_q[i]     <= ADDR_RESET;
                pred_q[i]   <= 1'b0;
                taken_q[i]  <= 1'b0;
                target_q[i] <= ADDR_RESET;
            end
        end else if (rdy_in) begin
            commit_flag_out   <= do_commit;
            store_commit_out  <= do_commit && (type_q[head_q] == ROB_TYPE_STORE);
            rollback_flag_out <= mispredict;
            if (do_commit) begin
                rd_to_reg_out <= rd_q[head_q];
                V_to_reg_out  <= value_q[head_q];
                Q_to_reg_out  <= idx_to_id(head_q);
            end

            if (mispredict) begin
                // Flush beats any allocation or CDB write in the same cycle.
                rollback_pc_out <= taken_q[head_q] ? target_q[head_q] : pc_q[head_q] + 32'd4;
                head_q          <= '0;
                tail_q          <= '0;
                count_q         <= '0;
                for (int i = 0; i < ROB_SIZE; i++) begin
                    valid_q[i] <= 1'b0;
                    ready_q[i] <= 1'b0;
                end
            end else begin
                if (do_commit) begin
                    valid_q[head_q] <= 1'b0;
                    ready_q[head_q] <= 1'b0;
                    head_q          <= head_q + 4'd1;
                end
                if (do_alloc) begin
                    valid_q[tail_q] <= 1'b1;
                    ready_q[tail_q] <= 1'b0;
                    type_q[tail_q]  <= rob_type_e'(alloc_type_in);
                    rd_q[tail_q]    <= alloc_rd_in;
                    pc_q[tail_q]    <= alloc_pc_in;
                    pred_q[tail_q]  <= alloc_pred_taken_in;
                    tail_q          <= tail_q + 4'd1;
                end
                // Only live entries accept results; stale ids after a flush are dropped.
                if (result_hit && valid_q[result_idx]) begin
                    ready_q[result_idx]  <= 1'b1;
                    value_q[result_idx]  <= result_value_in;
                    taken_q[result_idx]  <= result_taken_in;
                    target_q[result_idx] <= result_target_in;
                end
                case ({do_alloc, do_commit})
                    2'b10:   count_q <= count_q + 5'd1;
                    2'b01:   count_q <= count_q - 5'd1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed self-checking bench for reorder_buffer
module tb_reorder_buffer;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        alloc_valid_in;
    logic [4:0]  alloc_rd_in;
    logic [1:0]  alloc_type_in;
    logic [31:0] alloc_pc_in;
    logic        alloc_pred_taken_in;
    logic [4:0]  alloc_id_out;
    logic        full_out;
    logic [4:0]  q1_id_in, q2_id_in;
    logic        q1_ready_out, q2_ready_out;
    logic [31:0] q1_value_out, q2_value_out;
    logic        result_valid_in;
    logic [4:0]  result_id_in;
    logic [31:0] result_value_in;
    logic        result_taken_in;
    logic [31:0] result_target_in;
    logic        commit_flag_out;
    logic [4:0]  rd_to_reg_out;
    logic [31:0] V_to_reg_out;
    logic [4:0]  Q_to_reg_out;
    logic        store_commit_out;
    logic        rollback_flag_out;
    logic [31:0] rollback_pc_out;

    int errors = 0;
    int checks = 0;

    always #5 clk_in = ~clk_in;

    reorder_buffer dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .alloc_valid_in(alloc_valid_in), .alloc_rd_in(alloc_rd_in),
        .alloc_type_in(alloc_type_in), .alloc_pc_in(alloc_pc_in),
        .alloc_pred_taken_in(alloc_pred_taken_in),
        .alloc_id_out(alloc_id_out), .full_out(full_out),
        .q1_id_in(q1_id_in), .q2_id_in(q2_id_in),
        .q1_ready_out(q1_ready_out), .q2_ready_out(q2_ready_out),
        .q1_value_out(q1_value_out), .q2_value_out(q2_value_out),
        .result_valid_in(result_valid_in), .result_id_in(result_id_in),
        .result_value_in(result_value_in), .result_taken_in(result_taken_in),
        .result_target_in(result_target_in),
        .commit_flag_out(commit_flag_out), .rd_to_reg_out(rd_to_reg_out),
        .V_to_reg_out(V_to_reg_out), .Q_to_reg_out(Q_to_reg_out),
        .store_commit_out(store_commit_out),
        .rollback_flag_out(rollback_flag_out), .rollback_pc_out(rollback_pc_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_valid_in      = 1'b0;
        alloc_rd_in         = 5'd0;
        alloc_type_in       = 2'd0;
        alloc_pc_in         = 32'd0;
        alloc_pred_taken_in = 1'b0;
        q1_id_in            = 5'd0;
        q2_id_in            = 5'd0;
        result_valid_in     = 1'b0;
        result_id_in        = 5'd0;
        result_value_in     = 32'd0;
        result_taken_in     = 1'b0;
        result_target_in    = 32'd0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rdy_in = 1'b1;
        rst_in = 1'b0;
        tick();
        tick();
        rst_in = 1'b1;
    endtask

    task automatic cdb(input logic [4:0] id, input logic [31:0] val,
                       input logic tk, input logic [31:0] tgt);
        result_valid_in  = 1'b1;
        result_id_in     = id;
        result_value_in  = val;
        result_taken_in  = tk;
        result_target_in = tgt;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        apply_reset();
        chk("rst_alloc_id", alloc_id_out, 1);
        chk("rst_full", full_out, 0);
        chk("rst_commit", commit_flag_out, 0);
        chk("rst_q_to_reg", Q_to_reg_out, 0);
        chk("rst_rd_to_reg", rd_to_reg_out, 0);
        chk("rst_rollback", rollback_flag_out, 0);
        chk("rst_rollback_pc", rollback_pc_out, 0);

        // In-order commit: 3 ALU entries, ids complete 2 then 1
        alloc_valid_in = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            alloc_rd_in = 5'(i);
            chk($sformatf("alloc_id_%0d", i), alloc_id_out, i);
            tick();
        end
        alloc_valid_in = 1'b0;
        cdb(5'd2, 32'h22, 1'b0, 32'd0);
        tick();
        chk("no_commit_id2_first", commit_flag_out, 0);
        cdb(5'd1, 32'h11, 1'b0, 32'd0);
        tick();
        result_valid_in = 1'b0;
        chk("no_commit_yet", commit_flag_out, 0);
        tick();
        chk("commit1_flag", commit_flag_out, 1);
        chk("commit1_q", Q_to_reg_out, 1);
        chk("commit1_rd", rd_to_reg_out, 1);
        chk("commit1_v", V_to_reg_out, 32'h11);
        tick();
        chk("commit2_flag", commit_flag_out, 1);
        chk("commit2_q", Q_to_reg_out, 2);
        chk("commit2_rd", rd_to_reg_out, 2);
        chk("commit2_v", V_to_reg_out, 32'h22);
        tick();
        chk("id3_uncommitted", commit_flag_out, 0);
        tick();
        chk("id3_still_uncommitted", commit_flag_out, 0);

        // Full, ignored 17th request, wrap of the tail
        apply_reset();
        alloc_valid_in = 1'b1;
        alloc_rd_in    = 5'd7;
        for (int i = 0; i < 16; i++) tick();
        chk("full_after_16", full_out, 1);
        chk("alloc_id_wrapped", alloc_id_out, 1);
        tick();
        chk("full_after_17th", full_out, 1);
        chk("alloc_id_17th_ignored", alloc_id_out, 1);
        cdb(5'd1, 32'h5, 1'b0, 32'd0);
        tick();
        result_valid_in = 1'b0;
        chk("still_full_before_commit", full_out, 1);
        tick();
        chk("wrap_commit_flag", commit_flag_out, 1);
        chk("wrap_commit_q", Q_to_reg_out, 1);
        chk("not_full_after_commit", full_out, 0);
        chk("regrant_id1", alloc_id_out, 1);
        tick();
        chk("full_again", full_out, 1);
        chk("alloc_id_after_wrap", alloc_id_out, 2);
        alloc_valid_in = 1'b0;

        // Mispredict taken: rollback to target, allocation in that cycle dropped
        apply_reset();
        alloc_valid_in = 1'b1;
        alloc_type_in  = 2'd2;
        alloc_pc_in    = 32'h100;
        alloc_pred_taken_in = 1'b0;
        tick();
        alloc_valid_in = 1'b0;
        cdb(5'd1, 32'h0, 1'b1, 32'h200);
        tick();
        result_valid_in = 1'b0;
        alloc_valid_in  = 1'b1;
        alloc_type_in   = 2'd0;
        chk("alloc_id_before_flush", alloc_id_out, 2);
        tick();
        alloc_valid_in = 1'b0;
        chk("mp_commit_flag", commit_flag_out, 1);
        chk("mp_rollback_flag", rollback_flag_out, 1);
        chk("mp_rollback_pc", rollback_pc_out, 32'h200);
        chk("mp_store", store_commit_out, 0);
        chk("mp_full", full_out, 0);
        chk("mp_alloc_id", alloc_id_out, 1);
        tick();
        chk("mp_rollback_pulse_end", rollback_flag_out, 0);
        chk("mp_commit_pulse_end", commit_flag_out, 0);

        // Mispredict not-taken with pc+4 wraparound
        apply_reset();
        alloc_valid_in = 1'b1;
        alloc_type_in  = 2'd2;
        alloc_pc_in    = 32'hFFFF_FFFC;
        alloc_pred_taken_in = 1'b1;
        tick();
        alloc_valid_in = 1'b0;
        cdb(5'd1, 32'h0, 1'b0, 32'h1234);
        tick();
        result_valid_in = 1'b0;
        tick();
        chk("nt_rollback_flag", rollback_flag_out, 1);
        chk("nt_rollback_pc_wrap", rollback_pc_out, 32'h0);

        // Correct prediction and store commit: no rollback, store pulse
        apply_reset();
        alloc_valid_in = 1'b1;
        alloc_type_in  = 2'd2;
        alloc_pc_in    = 32'h40;
        alloc_pred_taken_in = 1'b1;
        tick();
        alloc_type_in  = 2'd1;
        alloc_rd_in    = 5'd0;
        tick();
        alloc_valid_in = 1'b0;
        cdb(5'd1, 32'h0, 1'b1, 32'h80);
        tick();
        cdb(5'd2, 32'h99, 1'b0, 32'h0);
        tick();
        result_valid_in = 1'b0;
        chk("br_ok_commit", commit_flag_out, 1);
        chk("br_ok_no_rollback", rollback_flag_out, 0);
        chk("br_ok_no_store", store_commit_out, 0);
        tick();
        chk("store_commit_flag", commit_flag_out, 1);
        chk("store_commit_pulse", store_commit_out, 1);
        chk("store_commit_q", Q_to_reg_out, 2);
        tick();
        chk("store_pulse_end", store_commit_out, 0);

        // Same-cycle CDB bypass on the query ports
        apply_reset();
        alloc_valid_in = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        alloc_valid_in = 1'b0;
        q1_id_in = 5'd4;
        q2_id_in = 5'd3;
        cdb(5'd4, 32'hDEAD, 1'b0, 32'h0);
        #1;
        chk("bypass_q1_ready", q1_ready_out, 1);
        chk("bypass_q1_value", q1_value_out, 32'hDEAD);
        chk("q2_not_ready", q2_ready_out, 0);
        chk("q2_value_zero", q2_value_out, 0);
        tick();
        result_valid_in = 1'b0;
        #1;
        chk("stored_q1_ready", q1_ready_out, 1);
        chk("stored_q1_value", q1_value_out, 32'hDEAD);
        q1_id_in = 5'd0;
        #1;
        chk("id0_not_ready", q1_ready_out, 0);
        chk("id0_value_zero", q1_value_out, 0);

        // rd=0 commit, stalled by rdy_in low
        apply_reset();
        alloc_valid_in = 1'b1;
        alloc_rd_in    = 5'd0;
        tick();
        alloc_valid_in = 1'b0;
        cdb(5'd1, 32'h77, 1'b0, 32'h0);
        tick();
        result_valid_in = 1'b0;
        rdy_in = 1'b0;
        tick();
        chk("stall_no_commit_a", commit_flag_out, 0);
        tick();
        chk("stall_no_commit_b", commit_flag_out, 0);
        rdy_in = 1'b1;
        tick();
        chk("rd0_commit_flag", commit_flag_out, 1);
        chk("rd0_rd_to_reg", rd_to_reg_out, 0);
        chk("rd0_v", V_to_reg_out, 32'h77);
        chk("rd0_q", Q_to_reg_out, 1);

        // Reset mid-operation with 5 entries and a commit pulse live
        apply_reset();
        alloc_valid_in = 1'b1;
        alloc_rd_in    = 5'd9;
        for (int i = 0; i < 5; i++) tick();
        alloc_valid_in = 1'b0;
        cdb(5'd1, 32'hAB, 1'b0, 32'h0);
        tick();
        result_valid_in = 1'b0;
        tick();
        chk("pre_reset_commit", commit_flag_out, 1);
        #2;
        rst_in = 1'b0;
        #1;
        chk("async_rst_commit", commit_flag_out, 0);
        chk("async_rst_q", Q_to_reg_out, 0);
        chk("async_rst_rd", rd_to_reg_out, 0);
        chk("async_rst_v", V_to_reg_out, 0);
        chk("async_rst_alloc_id", alloc_id_out, 1);
        tick();
        rst_in = 1'b1;
        q1_id_in = 5'd2;
        tick();
        chk("post_rst_commit", commit_flag_out, 0);
        chk("post_rst_alloc_id", alloc_id_out, 1);
        chk("post_rst_q1_not_ready", q1_ready_out, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
